udp_rx_port_filter: RTL

- Sits directly upstream of the UDP echo payload FIFO stage.
- Consumes the UDP RX header and payload streams from the UDP/IP stack.
- Passes only the payload of frames whose destination port matches LISTEN_PORT, and discards all other frames.
- For each matched frame, emits a reply header with source and destination swapped, for the TX UDP path.

---
 rtl/udp_echo_pkg.sv | 33 +++
 rtl/udp_rx_port_filter_if.sv | 66 ++++++
 rtl/udp_reply_hdr_reg.sv | 41 ++++
 rtl/udp_rx_port_filter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/udp_echo_pkg.sv
// ============================================================================
// Module      : udp_echo_pkg
// Description : Shared types and constants for the UDP echo receive path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_echo_pkg;

  localparam logic [15:0] LISTEN_PORT_DEFAULT = 16'd1234;
  localparam logic [15:0] UDP_HDR_LEN         = 16'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } reply_hdr_t;

  // UDP length counts the 8-byte header, so anything larger carries payload.
  function automatic logic has_payload(input logic [15:0] udp_length);
    return udp_length > UDP_HDR_LEN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udp_rx_port_filter_if.sv
// ============================================================================
// Module      : udp_rx_port_filter_if
// Description : RX header/payload in, filtered payload and reply header out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface udp_rx_port_filter_if;

  logic        s_udp_hdr_valid;
  logic        s_udp_hdr_ready;
  logic [31:0] s_udp_ip_source_ip;
  logic [15:0] s_udp_source_port;
  logic [15:0] s_udp_dest_port;
  logic [15:0] s_udp_length;

  logic [7:0]  s_udp_payload_axis_tdata;
  logic        s_udp_payload_axis_tvalid;
  logic        s_udp_payload_axis_tlast;
  logic        s_udp_payload_axis_tuser;
  logic        s_udp_payload_axis_tready;

  logic [7:0]  m_udp_payload_axis_tdata;
  logic        m_udp_payload_axis_tvalid;
  logic        m_udp_payload_axis_tlast;
  logic        m_udp_payload_axis_tuser;
  logic        m_udp_payload_axis_tready;

  logic        m_reply_hdr_valid;
  logic        m_reply_hdr_ready;
  logic [31:0] m_reply_ip_dest_ip;
  logic [15:0] m_reply_source_port;
  logic [15:0] m_reply_dest_port;
  logic [15:0] m_reply_length;

  // Environment side: drives RX streams and downstream readies.
  modport master (
    output s_udp_hdr_valid, s_udp_ip_source_ip, s_udp_source_port,
           s_udp_dest_port, s_udp_length,
           s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
           s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
           m_udp_payload_axis_tready, m_reply_hdr_ready,
    input  s_udp_hdr_ready, s_udp_payload_axis_tready,
           m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
           m_udp_payload_axis_tlast, m_udp_payload_axis_tuser,
           m_reply_hdr_valid, m_reply_ip_dest_ip, m_reply_source_port,
           m_reply_dest_port, m_reply_length
  );

  // Filter side.
  modport slave (
    input  s_udp_hdr_valid, s_udp_ip_source_ip, s_udp_source_port,
           s_udp_dest_port, s_udp_length,
           s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
           s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
           m_udp_payload_axis_tready, m_reply_hdr_ready,
    output s_udp_hdr_ready, s_udp_payload_axis_tready,
           m_udp_payload_axis_tdata, m_udp_payload_axis_tvalid,
           m_udp_payload_axis_tlast, m_udp_payload_axis_tuser,
           m_reply_hdr_valid, m_reply_ip_dest_ip, m_reply_source_port,
           m_reply_dest_port, m_reply_length
  );

endinterface

`default_nettype wire

// File: rtl/udp_reply_hdr_reg.sv
// ============================================================================
// Module      : udp_reply_hdr_reg
// Description : One-entry valid/ready holding register for the reply header.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_reply_hdr_reg
  import udp_echo_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       load,
  input  wire reply_hdr_t load_hdr,
  output logic            valid,
  input  wire logic       ready,
  output reply_hdr_t      hdr
);

  logic       r_valid;
  reply_hdr_t r_hdr;

  // Loads only arrive while empty, so load never races with a pending reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_hdr   <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_hdr   <= load_hdr;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign hdr   = r_hdr;

endmodule

`default_nettype wire

// File: rtl/udp_rx_port_filter.sv
// ============================================================================
// Module      : udp_rx_port_filter
// Description : Passes payload of frames addressed to LISTEN_PORT, drops the
//               rest, and emits a swapped reply header per matched frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_rx_port_filter
  import udp_echo_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = LISTEN_PORT_DEFAULT,
  parameter int          CNT_WIDTH   = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  udp_rx_port_filter_if.slave  bus,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_match_count;
  logic [CNT_WIDTH-1:0] r_drop_count;
  logic [CNT_WIDTH-1:0] r_err_count;

  logic       w_reply_valid;
  reply_hdr_t w_reply_hdr;
  reply_hdr_t w_capture;
  logic       w_hdr_ready;
  logic       w_hdr_fire;
  logic       w_port_match;
  logic       w_payload;
  logic       w_s_tready;
  logic       w_m_tvalid;
  logic       w_beat_fire;
  logic       w_beat_last;

  // A new header must wait for the previous reply to drain.
  assign w_hdr_ready  = (r_state == IDLE) && !w_reply_valid;
  assign w_hdr_fire   = bus.s_udp_hdr_valid && w_hdr_ready;
  assign w_port_match = (bus.s_udp_dest_port == LISTEN_PORT);
  assign w_payload    = has_payload(bus.s_udp_length);
  assign w_beat_fire  = bus.s_udp_payload_axis_tvalid && w_s_tready;
  assign w_beat_last  = w_beat_fire && bus.s_udp_payload_axis_tlast;

  assign w_capture.dest_ip  = bus.s_udp_ip_source_ip;
  assign w_capture.src_port = bus.s_udp_dest_port;
  assign w_capture.dst_port = bus.s_udp_source_port;
  assign w_capture.length   = bus.s_udp_length;

  always_comb begin
    w_s_tready = 1'b0;
    w_m_tvalid = 1'b0;
    case (r_state)
      PASS: begin
        w_s_tready = bus.m_udp_payload_axis_tready;
        w_m_tvalid = bus.s_udp_payload_axis_tvalid;
      end
      DROP:    w_s_tready = 1'b1;
      default: w_s_tready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_match_count <= '0;
      r_drop_count  <= '0;
      r_err_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hdr_fire) begin
            if (w_port_match) begin
              r_match_count <= r_match_count + 1'b1;
              if (w_payload) r_state <= PASS;
            end else begin
              r_drop_count <= r_drop_count + 1'b1;
              if (w_payload) r_state <= DROP;
            end
          end
        end
        PASS: begin
          if (w_beat_last) begin
            r_state <= IDLE;
            if (bus.s_udp_payload_axis_tuser) r_err_count <= r_err_count + 1'b1;
          end
        end
        DROP: begin
          if (w_beat_last) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  udp_reply_hdr_reg u_reply_hdr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_hdr_fire && w_port_match),
    .load_hdr (w_capture),
    .valid    (w_reply_valid),
    .ready    (bus.m_reply_hdr_ready),
    .hdr      (w_reply_hdr)
  );

  assign bus.s_udp_hdr_ready           = w_hdr_ready;
  assign bus.s_udp_payload_axis_tready = w_s_tready;
  assign bus.m_udp_payload_axis_tvalid = w_m_tvalid;
  assign bus.m_udp_payload_axis_tdata  = bus.s_udp_payload_axis_tdata;
  assign bus.m_udp_payload_axis_tlast  = bus.s_udp_payload_axis_tlast;
  assign bus.m_udp_payload_axis_tuser  = bus.s_udp_payload_axis_tuser;

  assign bus.m_reply_hdr_valid   = w_reply_valid;
  assign bus.m_reply_ip_dest_ip  = w_reply_hdr.dest_ip;
  assign bus.m_reply_source_port = w_reply_hdr.src_port;
  assign bus.m_reply_dest_port   = w_reply_hdr.dst_port;
  assign bus.m_reply_length      = w_reply_hdr.length;

  assign match_count = r_match_count;
  assign drop_count  = r_drop_count;
  assign err_count   = r_err_count;

endmodule

`default_nettype wire
